// File: rtl/adc_ddr_pattern_tx.sv
// Generates ADC-like DDR rise/fall word pairs with a fixed preamble, a selectable test pattern and a trailing gap.
// Every output is registered, so a start sampled at edge N shows the first preamble word at edge N+1.
module adc_ddr_pattern_tx #(
  parameter int                 DATA_WIDTH   = 8,
  parameter int                 LEN_WIDTH    = 16,
  parameter logic [15:0]        PRBS_SEED    = 16'hACE1,
  parameter int                 PREAMBLE_LEN = 4,
  parameter int                 GAP_LEN      = 2
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  continuous,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] user_word_a,
  input  logic [DATA_WIDTH-1:0] user_word_b,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic [DATA_WIDTH-1:0] data_rise,
  output logic [DATA_WIDTH-1:0] data_fall,
  output logic                  dco_en,
  output logic                  valid,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, BURST, GAP} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] word_a_q, word_a_d, word_b_q, word_b_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  cont_q, cont_d;
  logic [DATA_WIDTH-1:0] rise_d, fall_d;
  logic                  dco_d, valid_d, busy_d, done_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    mode_d   = mode_q;
    word_a_d = word_a_q;
    word_b_d = word_b_q;
    len_d    = len_q;
    cont_d   = cont_q;
    rise_d   = '0;
    fall_d   = '0;
    dco_d    = 1'b0;
    valid_d  = 1'b0;
    busy_d   = (state_q != IDLE);
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d   = mode;
          word_a_d = user_word_a;
          word_b_d = user_word_b;
          len_d    = burst_len;
          cont_d   = continuous;
          cnt_d    = '0;
          lfsr_d   = PRBS_SEED;
          state_d  = (burst_len == '0 && !continuous) ? GAP : PREAMBLE;
        end
      end

      PREAMBLE: begin
        rise_d = DATA_WIDTH'(8'hA5);
        fall_d = DATA_WIDTH'(8'h5A);
        dco_d  = 1'b1;
        if (cnt_q == LEN_WIDTH'(PREAMBLE_LEN - 1)) begin
          cnt_d   = '0;
          state_d = BURST;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      BURST: begin
        dco_d   = 1'b1;
        valid_d = 1'b1;
        case (mode_q)
          2'd0: begin
            rise_d = word_a_q;
            fall_d = word_b_q;
          end
          2'd1: begin
            rise_d = DATA_WIDTH'(cnt_q[7:0]);
            fall_d = DATA_WIDTH'(~cnt_q[7:0]);
          end
          2'd2: begin
            rise_d = DATA_WIDTH'(lfsr_q[15:8]);
            fall_d = DATA_WIDTH'(lfsr_q[7:0]);
          end
          default: begin
            rise_d = cnt_q[0] ? DATA_WIDTH'(8'hAA) : DATA_WIDTH'(8'h55);
            fall_d = cnt_q[0] ? DATA_WIDTH'(8'h55) : DATA_WIDTH'(8'hAA);
          end
        endcase
        // Fibonacci x^16+x^14+x^13+x^11+1, one step per payload word
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        cnt_d  = cnt_q + 1'b1;
        if (cont_q ? stop : (cnt_q == len_q - 1'b1)) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end

      GAP: begin
        if (cnt_q == LEN_WIDTH'(GAP_LEN - 1)) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lfsr_q    <= PRBS_SEED;
      mode_q    <= '0;
      word_a_q  <= '0;
      word_b_q  <= '0;
      len_q     <= '0;
      cont_q    <= 1'b0;
      data_rise <= '0;
      data_fall <= '0;
      dco_en    <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      mode_q    <= mode_d;
      word_a_q  <= word_a_d;
      word_b_q  <= word_b_d;
      len_q     <= len_d;
      cont_q    <= cont_d;
      data_rise <= rise_d;
      data_fall <= fall_d;
      dco_en    <= dco_d;
      valid     <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule
